uc_arbiter: RTL and testbench

- Producer side of the unit-clause queue (uc_queue).
- Collects unit literals discovered by NUM_ENG BCP engines and serializes them into the queue's push/uca2ucq port under round-robin arbitration.
- Coalesces duplicate literals pending in the same cycle.
- Detects complementary literals (x and ~x) pending together, then raises a sticky conflict and halts all pushes.

---
 rtl/uc_arbiter.sv | 150 +++++++++++++++
 tb/tb_uc_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_arbiter.sv
// ----------------------------------------------------------------------------
// uc_arbiter
//   Producer side of the unit-clause queue. Collects unit literals discovered
//   by NUM_ENG BCP engines into per-engine holding slots and serializes them
//   into the uc_queue push port under round-robin arbitration. Identical
//   literals held at the same time are coalesced into a single push.
//   Complementary literals (x and ~x) held together raise a sticky conflict
//   that halts all further pushes and acceptances until reset.
//
// Literal format: MSB = polarity (1 = negated), [LIT_W-2:0] = variable index,
// variable index 0 is the null literal.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   req_valid     per-engine request valid
//   req_lit       per-engine unit literal
//   req_ready     per-engine slot free (accept on valid & ready at posedge)
//   ucq_full      uc_queue full; suppresses pushing
//   push          push strobe to uc_queue (combinational from held state)
//   uca2ucq       literal to uc_queue, 0 when push = 0
//   conflict      sticky conflict flag
//   conflict_var  variable index of the detected conflict
// ----------------------------------------------------------------------------
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 64
`endif

module uc_arbiter #(
  parameter int NUM_ENG     = 4,
  parameter int LIT_IDX_MAX = `LIT_IDX_MAX,
  parameter int LIT_W       = $clog2(LIT_IDX_MAX) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_ENG-1:0]              req_valid,
  input  logic [NUM_ENG-1:0][LIT_W-1:0]   req_lit,
  output logic [NUM_ENG-1:0]              req_ready,
  input  logic                            ucq_full,
  output logic                            push,
  output logic [LIT_W-1:0]                uca2ucq,
  output logic                            conflict,
  output logic [LIT_W-2:0]                conflict_var
);

  localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  logic [NUM_ENG-1:0] hold_v;
  logic [LIT_W-1:0]   hold_lit [NUM_ENG];
  logic [PTR_W-1:0]   rr_ptr;

  logic               conf_hit;
  logic [LIT_W-2:0]   conf_idx;
  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [LIT_W-1:0]   grant_lit;
  logic [NUM_ENG-1:0] clr_mask;
  logic [NUM_ENG-1:0] accept;
  logic               push_en;

  // Complementary-pair detection over held slots. The first hit in (i, j)
  // order is the lowest-index pair; both members share the variable index.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    conf_hit = 1'b0;
    conf_idx = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      for (int j = i + 1; j < NUM_ENG; j++) begin
        if (!conf_hit && hold_v[i] && hold_v[j] &&
            (hold_lit[i][LIT_W-2:0] == hold_lit[j][LIT_W-2:0]) &&
            (hold_lit[i][LIT_W-1] != hold_lit[j][LIT_W-1])) begin
          conf_hit = 1'b1;
          conf_idx = hold_lit[i][LIT_W-2:0];
        end
      end
    end
  end

  // Round-robin grant: first held slot at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_ENG; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_ENG) idx = idx - NUM_ENG;
      if (!grant_found && hold_v[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  assign grant_lit = hold_lit[grant_idx];
  assign next_ptr  = (grant_idx == PTR_W'(NUM_ENG - 1)) ? '0 : grant_idx + 1'b1;

  // Every held copy of the granted literal retires with the one push.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      clr_mask[i] = hold_v[i] && (hold_lit[i] == grant_lit);
    end
  end

  // A pending conflict wins over pushing in the cycle it is detected.
  assign push_en   = !rst && !conflict && !conf_hit && !ucq_full && grant_found;
  assign push      = push_en;
  assign uca2ucq   = push_en ? grant_lit : '0;
  // Readiness follows the registered slot state, so a slot cleared at an edge
  // only becomes acceptable in the following cycle.
  assign req_ready = rst ? '1 : (~hold_v & {NUM_ENG{~conflict}});
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      hold_v       <= '0;
      rr_ptr       <= '0;
      conflict     <= 1'b0;
      conflict_var <= '0;
    end else if (!conflict) begin
      if (conf_hit) begin
        conflict     <= 1'b1;
        conflict_var <= conf_idx;
      end
      // accept only reaches empty slots, clr_mask only held ones: disjoint.
      for (int i = 0; i < NUM_ENG; i++) begin
        if (accept[i]) begin
          hold_v[i] <= (req_lit[i][LIT_W-2:0] != '0);  // null literal dropped
        end else if (push_en && clr_mask[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
      if (push_en) rr_ptr <= next_ptr;
    end
  end

  // NOTE: literal storage has no reset; it is only observed when the matching
  // hold_v bit is set, and hold_v itself is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENG; i++) begin
      if (!rst && !conflict && accept[i]) hold_lit[i] <= req_lit[i];
    end
  end

endmodule

// File: tb/tb_uc_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uc_arbiter
//   Self-checking bench for uc_arbiter. Directed sequences for the key
//   scenarios followed by randomized traffic, all compared each cycle against
//   a behavioural model of held literals, round-robin pointer and conflict.
// ----------------------------------------------------------------------------
module tb_uc_arbiter;

  localparam int N  = 4;
  localparam int LW = 7;  // LIT_IDX_MAX = 64

  typedef logic [N-1:0][LW-1:0] lits_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  lits_t             req_lit;
  logic [N-1:0]      req_ready;
  logic              ucq_full;
  logic              push;
  logic [LW-1:0]     uca2ucq;
  logic              conflict;
  logic [LW-2:0]     conflict_var;

  uc_arbiter #(.NUM_ENG(N), .LIT_IDX_MAX(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_lit      (req_lit),
    .req_ready    (req_ready),
    .ucq_full     (ucq_full),
    .push         (push),
    .uca2ucq      (uca2ucq),
    .conflict     (conflict),
    .conflict_var (conflict_var)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model state
  bit            m_v   [N];
  logic [LW-1:0] m_lit [N];
  int            m_rr;
  bit            m_conf;
  int            m_cvar;

  // Observations from the most recent step, plus per-literal push counts
  logic          o_push;
  logic [LW-1:0] o_lit;
  logic [N-1:0]  o_ready;
  logic          o_conf;
  logic [LW-2:0] o_cvar;
  int            push_cnt [128];

  function automatic lits_t mk(input int a, input int b, input int c, input int d);
    lits_t l;
    l[0] = LW'(a);
    l[1] = LW'(b);
    l[2] = LW'(c);
    l[3] = LW'(d);
    return l;
  endfunction

  // One clock cycle: drive inputs, compare all outputs against the model,
  // advance the model, then let the edge happen.
  task automatic step(input logic r, input logic [N-1:0] v, input lits_t l, input logic f);
    bit            pair;
    int            pair_var;
    int            g;
    bit            e_push;
    logic [LW-1:0] e_lit;
    logic [N-1:0]  e_ready;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_lit   = l;
    ucq_full  = f;
    #1;
    pair = 0;
    pair_var = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (!pair && m_v[i] && m_v[j] && m_lit[i][5:0] == m_lit[j][5:0] &&
            m_lit[i][6] != m_lit[j][6]) begin
          pair = 1;
          pair_var = int'(m_lit[i][5:0]);
        end
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && m_v[(m_rr + k) % N]) g = (m_rr + k) % N;
    e_push = !r && !m_conf && !pair && !f && (g >= 0);
    e_lit  = '0;
    if (e_push) e_lit = m_lit[g];
    for (int i = 0; i < N; i++) e_ready[i] = r || (!m_v[i] && !m_conf);

    o_push  = push;
    o_lit   = uca2ucq;
    o_ready = req_ready;
    o_conf  = conflict;
    o_cvar  = conflict_var;
    if (push) push_cnt[uca2ucq]++;
    check("push", 32'(push), 32'(e_push));
    check("uca2ucq", 32'(uca2ucq), 32'(e_lit));
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("conflict", 32'(conflict), 32'(m_conf));
    check("conflict_var", 32'(conflict_var), 32'(m_cvar));

    if (r) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_rr = 0;
      m_conf = 0;
      m_cvar = 0;
    end else if (!m_conf) begin
      if (pair) begin
        m_conf = 1;
        m_cvar = pair_var;
      end else if (e_push) begin
        for (int i = 0; i < N; i++)
          if (i != g && m_v[i] && m_lit[i] == e_lit) m_v[i] = 0;
        m_v[g] = 0;
        m_rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (v[i] && e_ready[i] && l[i][5:0] != 0) begin
          m_v[i] = 1;
          m_lit[i] = l[i];
        end
    end
    @(posedge clk);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 128; i++) push_cnt[i] = 0;
  endtask

  initial begin
    logic [N-1:0] rv;
    lits_t        rl;
    rst = 1'b1;
    req_valid = '0;
    req_lit = '0;
    ucq_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0;
      m_lit[i] = '0;
    end
    m_rr = 0;
    m_conf = 0;
    m_cvar = 0;
    clear_counts();

    // Reset, then idle
    step(1, '0, '0, 0);
    step(1, '0, '0, 0);
    step(0, '0, '0, 0);
    check("idle_ready", 32'(o_ready), 32'hF);
    check("idle_push", 32'(o_push), 32'h0);
    check("idle_lit", 32'(o_lit), 32'h0);

    // Four engines at once: pushes 2,4,6,8 on consecutive cycles
    step(0, 4'hF, mk(2, 4, 6, 8), 0);
    for (int k = 0; k < 4; k++) begin
      step(0, '0, '0, 0);
      check("rr_order", 32'(o_lit), 32'(2 * (k + 1)));
    end
    step(0, '0, '0, 0);
    check("rr_drained", 32'(o_push), 32'h0);

    // Duplicate 5 from engines 1 and 3: one push, rr_ptr moves to 2
    clear_counts();
    step(0, 4'b1010, mk(0, 5, 0, 5), 0);
    step(0, '0, '0, 0);
    step(0, '0, '0, 0);
    check("dup_ready", 32'(o_ready), 32'hF);
    check("dup_count", 32'(push_cnt[5]), 32'd1);
    step(0, 4'b0101, mk(7, 0, 9, 0), 0);
    step(0, '0, '0, 0);
    check("rr_after_dup", 32'(o_lit), 32'd9);
    step(0, '0, '0, 0);

    // ucq_full holds 10 for three cycles
    clear_counts();
    step(0, 4'b0001, mk(10, 0, 0, 0), 1);
    for (int k = 0; k < 3; k++) begin
      step(0, '0, '0, 1);
      check("full_hold", 32'(o_push), 32'h0);
    end
    step(0, '0, '0, 0);
    check("full_release", 32'(o_lit), 32'd10);
    step(0, '0, '0, 0);
    check("full_once", 32'(push_cnt[10]), 32'd1);

    // Complementary literals 3 and ~3
    clear_counts();
    step(0, 4'b0101, mk(8'h03, 0, 8'h43, 0), 0);
    step(0, '0, '0, 0);
    step(0, 4'hF, mk(1, 2, 3, 4), 0);
    check("conf_flag", 32'(o_conf), 32'h1);
    check("conf_var", 32'(o_cvar), 32'd3);
    check("conf_ready", 32'(o_ready), 32'h0);
    step(0, 4'hF, mk(1, 2, 3, 4), 0);
    check("conf_nopush", 32'(push_cnt[3] + push_cnt[8'h43]), 32'd0);
    step(1, '0, '0, 0);
    step(0, '0, '0, 0);
    check("conf_cleared", 32'(o_conf), 32'h0);
    check("conf_ready_back", 32'(o_ready), 32'hF);

    // Null literal accepted and dropped
    clear_counts();
    step(0, 4'b0010, mk(0, 0, 0, 0), 0);
    step(0, '0, '0, 0);
    check("null_ready", 32'(o_ready[1]), 32'h1);
    check("null_nopush", 32'(push_cnt[0]), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        rv[i] = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 9) == 0) rl[i] = '0;
        else rl[i] = {($urandom_range(0, 9) == 0), 6'($urandom_range(1, 5))};
      end
      step(($urandom_range(0, 39) == 0), rv, rl, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
